// File: rtl/river_crossing_fsm.sv
// ============================================================================
//  Module      : river_crossing_fsm
//  Description : River-crossing puzzle controller. It checks each crossing
//                request for capacity, item position and unattended
//                conflicts, then runs the boat transit. It ends in DONE or
//                FAILED.
//                Optional macro RIVER_CROSSING_FORMAL_EN embeds assertions
//                and a cover.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module river_crossing_fsm #(
  parameter int                         N_ITEMS      = 3,
  parameter int                         CAPACITY     = 1,
  parameter logic [N_ITEMS*N_ITEMS-1:0] CONFLICT     = 9'h022,
  parameter int                         CROSS_CYCLES = 2,
  parameter int                         MOVE_W       = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  input  logic [N_ITEMS-1:0] sel,
  output logic               ready,
  output logic               reject,
  output logic               busy,
  output logic [N_ITEMS-1:0] bank,
  output logic               bank_person,
  output logic [MOVE_W-1:0]  moves,
  output logic               done,
  output logic               failed
);

  localparam int c_CNT_W = (CROSS_CYCLES > 1) ? $clog2(CROSS_CYCLES) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CROSS  = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;
  localparam logic [1:0] S_FAILED = 2'd3;

  logic [1:0]         r_state;
  logic [N_ITEMS-1:0] r_bank;
  logic [N_ITEMS-1:0] r_sel;
  logic               r_person;
  logic [MOVE_W-1:0]  r_moves;
  logic               r_reject;
  logic [c_CNT_W-1:0] r_cnt;

  logic [N_ITEMS-1:0] w_away;
  logic [N_ITEMS-1:0] w_left;
  logic [N_ITEMS-1:0] w_bank_next;
  logic               w_legal;
  logic               w_conflict;
  logic               w_arrive;

  function automatic int popcount(input logic [N_ITEMS-1:0] v);
    int count;
    count = 0;
    for (int i = 0; i < N_ITEMS; i++) count += int'(v[i]);
    return count;
  endfunction

  // Items on the opposite bank from the person can be neither loaded nor left behind.
  assign w_away      = r_bank ^ {N_ITEMS{r_person}};
  assign w_left      = ~w_away & ~sel;
  assign w_legal     = (popcount(sel) <= CAPACITY) && ((sel & w_away) == '0);
  assign w_bank_next = r_bank ^ r_sel;
  assign w_arrive    = (r_state == S_CROSS) && (r_cnt == '0);

  always_comb begin
    w_conflict = 1'b0;
    for (int i = 0; i < N_ITEMS; i++) begin
      for (int j = 0; j < N_ITEMS; j++) begin
        if (i != j && w_left[i] && w_left[j] &&
            (CONFLICT[i*N_ITEMS+j] || CONFLICT[j*N_ITEMS+i]))
          w_conflict = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_bank   <= '0;
      r_sel    <= '0;
      r_person <= 1'b0;
      r_moves  <= '0;
      r_reject <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_reject <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (go) begin
            if (!w_legal) begin
              r_reject <= 1'b1;
            end else if (w_conflict) begin
              r_state <= S_FAILED;
            end else begin
              r_sel   <= sel;
              r_cnt   <= c_CNT_W'(CROSS_CYCLES - 1);
              r_state <= S_CROSS;
            end
          end
        end
        S_CROSS: begin
          if (w_arrive) begin
            r_bank   <= w_bank_next;
            r_person <= ~r_person;
            if (r_moves != '1) r_moves <= r_moves + 1'b1;
            r_state  <= ((&w_bank_next) && !r_person) ? S_DONE : S_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready       = (r_state == S_IDLE);
  assign busy        = (r_state == S_CROSS);
  assign done        = (r_state == S_DONE);
  assign failed      = (r_state == S_FAILED);
  assign reject      = r_reject;
  assign bank        = r_bank;
  assign bank_person = r_person;
  assign moves       = r_moves;

`ifdef RIVER_CROSSING_FORMAL_EN
  logic r_f_valid;
  logic r_f_failed;
  logic r_f_person;
  logic r_f_arrive;

  always_ff @(posedge clk) begin
    r_f_valid  <= !rst;
    r_f_failed <= failed;
    r_f_person <= r_person;
    r_f_arrive <= w_arrive;
  end

  always_comb begin
    if (done) assert ((&r_bank) && r_person);
    if (r_f_valid && !rst && r_f_failed) assert (failed);
    if (r_f_valid && !rst && !r_f_arrive) assert (r_person == r_f_person);
    assert (popcount(r_sel) <= CAPACITY);
    cover (done);
  end
`endif

endmodule

`default_nettype wire
